// File: rtl/pktstat_pkg.sv
// Shared definitions for the packet statistics status arbiter:
// tap identifiers, status-word layout and the round-robin pick helper.
package pktstat_pkg;

    localparam int NTAPS = 4;

    localparam int TAP_RX   = 0;
    localparam int TAP_CRC  = 1;
    localparam int TAP_TX   = 2;
    localparam int TAP_GATE = 3;

    localparam int DATA_W    = 31;
    localparam int ID_LSB    = 26;
    localparam int ABORT_BIT = 19;
    localparam int LEN_LSB   = 2;
    localparam int LEN_W     = 17;
    localparam int ENT_W     = LEN_W + 1;

    // Tag field is 3'b1xx: the top bit marks an arbiter-sourced word
    localparam logic [2:0] TAG_BIT = 3'b100;

    typedef logic [1:0] tap_id_t;

    typedef struct packed {
        logic             abort;
        logic [LEN_W-1:0] len;
    } tap_ent_t;

    typedef struct packed {
        logic    hit;
        tap_id_t id;
    } grant_t;

    function automatic logic [DATA_W-1:0] status_word(tap_id_t id, tap_ent_t e);
        logic [DATA_W-1:0] w;
        w                    = '0;
        w[ID_LSB +: 3]       = TAG_BIT | {1'b0, id};
        w[ABORT_BIT]         = e.abort;
        w[LEN_LSB +: LEN_W]  = e.len;
        return w;
    endfunction

    // First requester at or after ptr, wrapping; lowest offset wins
    function automatic grant_t rr_pick(logic [NTAPS-1:0] req, tap_id_t ptr);
        grant_t  g;
        tap_id_t idx;
        g = '0;
        for (int k = NTAPS - 1; k >= 0; k--) begin
            idx = ptr + tap_id_t'(k);
            if (req[idx]) begin
                g.hit = 1'b1;
                g.id  = idx;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/pktstat_arbiter_tapfifo.sv
// Single-tap synchronous FIFO holding {abort, len} events.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module pktstat_tapfifo
    import pktstat_pkg::*;
#(
    parameter int LGFIFO = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_push,
    input  tap_ent_t        i_data,
    input  logic            i_pop,
    output tap_ent_t        o_data,
    output logic            o_empty,
    output logic [LGFIFO:0] o_fill
);

    localparam int DEPTH = 1 << LGFIFO;

    tap_ent_t          mem [DEPTH];
    logic [LGFIFO-1:0] wr_ptr;
    logic [LGFIFO-1:0] rd_ptr;
    logic [LGFIFO:0]   fill;
    logic              full;
    logic              do_push;
    logic              do_pop;

    // fill never exceeds DEPTH, so its top bit alone flags full
    assign full    = fill[LGFIFO];
    assign o_empty = (fill == '0);
    assign o_fill  = fill;
    assign o_data  = mem[rd_ptr];

    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!full || do_pop);

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/pktstat_arbiter.sv
// Merges four monitor taps into one status stream via per-tap FIFOs
// and a round-robin scheduler; counts overflow drops per tap.
module pktstat_arbiter
    import pktstat_pkg::*;
#(
    parameter int LGFIFO = 2,
    parameter int DROPW  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NTAPS-1:0]       i_valid,
    input  logic [NTAPS-1:0]       i_abort,
    input  logic [NTAPS*LEN_W-1:0] i_len,
    input  logic                   i_clr_drops,
    output logic                   o_valid,
    output logic [DATA_W-1:0]      o_data,
    output logic [NTAPS*DROPW-1:0] o_drops
);

    tap_ent_t         head  [NTAPS];
    logic [LGFIFO:0]  fill  [NTAPS];
    logic [DROPW-1:0] drops [NTAPS];
    logic [NTAPS-1:0] empty;
    logic [NTAPS-1:0] pop;
    logic [NTAPS-1:0] drop;
    tap_id_t          ptr;
    grant_t           gnt;

    assign gnt = rr_pick(~empty, ptr);

    for (genvar s = 0; s < NTAPS; s++) begin : g_tap
        tap_ent_t ent;

        assign ent.abort = i_abort[s];
        assign ent.len   = i_len[LEN_W*s +: LEN_W];
        assign pop[s]    = gnt.hit && (gnt.id == tap_id_t'(s));
        assign drop[s]   = i_valid[s] && fill[s][LGFIFO] && !pop[s];

        pktstat_tapfifo #(
            .LGFIFO (LGFIFO)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_push  (i_valid[s]),
            .i_data  (ent),
            .i_pop   (pop[s]),
            .o_data  (head[s]),
            .o_empty (empty[s]),
            .o_fill  (fill[s])
        );

        // Clear wins over a same-cycle drop; counter sticks at all-ones
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                drops[s] <= '0;
            end else if (i_clr_drops) begin
                drops[s] <= '0;
            end else if (drop[s] && !(&drops[s])) begin
                drops[s] <= drops[s] + 1'b1;
            end
        end

        assign o_drops[DROPW*s +: DROPW] = drops[s];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            ptr     <= '0;
        end else begin
            o_valid <= gnt.hit;
            o_data  <= gnt.hit ? status_word(gnt.id, head[gnt.id]) : '0;
            if (gnt.hit) begin
                ptr <= gnt.id + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pktstat_arbiter.sv
// Bench for pktstat_arbiter: directed vector table, multi-cycle corner
// sequences and random traffic against a queue-based reference model.
module tb_pktstat_arbiter;

    localparam int LGFIFO = 2;
    localparam int DROPW  = 8;
    localparam int DEPTH  = 1 << LGFIFO;
    localparam int DMAX   = (1 << DROPW) - 1;

    logic              clk = 1'b0;
    logic              i_reset;
    logic [3:0]        i_valid;
    logic [3:0]        i_abort;
    logic [67:0]       i_len;
    logic              i_clr_drops;
    logic              o_valid;
    logic [30:0]       o_data;
    logic [4*DROPW-1:0] o_drops;

    pktstat_arbiter #(
        .LGFIFO (LGFIFO),
        .DROPW  (DROPW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_abort     (i_abort),
        .i_len       (i_len),
        .i_clr_drops (i_clr_drops),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_drops     (o_drops)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [17:0] q [4][$];
    int          ptr;
    int          mdrop   [4];
    int          emitted [4];
    int          offered [4];
    logic        exp_v;
    logic [30:0] exp_d;

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  ab;
        logic [67:0] len;
        logic        exp_v;
        logic [30:0] exp_d;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [30:0] word(int g, logic [17:0] e);
        logic [31:0] w;
        w = 32'h1000_0000 + (32'(g) << 26) + (32'(e[17]) << 19) + (32'(e[16:0]) << 2);
        return w[30:0];
    endfunction

    function automatic logic [4*DROPW-1:0] exp_drops();
        logic [4*DROPW-1:0] d;
        for (int s = 0; s < 4; s++) d[DROPW*s +: DROPW] = DROPW'(mdrop[s]);
        return d;
    endfunction

    task automatic model_step();
        int g;
        logic [17:0] e;
        if (i_reset) begin
            for (int s = 0; s < 4; s++) begin
                q[s].delete();
                mdrop[s] = 0;
            end
            ptr   = 0;
            exp_v = 1'b0;
            exp_d = '0;
            return;
        end
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && q[(ptr + k) % 4].size() > 0) g = (ptr + k) % 4;
        end
        if (g >= 0) begin
            e     = q[g].pop_front();
            exp_v = 1'b1;
            exp_d = word(g, e);
            ptr   = (g + 1) % 4;
        end else begin
            exp_v = 1'b0;
            exp_d = '0;
        end
        for (int s = 0; s < 4; s++) begin
            if (i_valid[s]) begin
                if (q[s].size() < DEPTH) q[s].push_back({i_abort[s], i_len[17*s +: 17]});
                else if (!i_clr_drops && mdrop[s] < DMAX) mdrop[s]++;
            end
        end
        if (i_clr_drops) begin
            for (int s = 0; s < 4; s++) mdrop[s] = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("valid", 64'(o_valid), 64'(exp_v));
        chk("data", 64'(o_data), 64'(exp_d));
        chk("drops", 64'(o_drops), 64'(exp_drops()));
        if (o_valid) emitted[o_data[27:26]]++;
    endtask

    task automatic idle();
        i_valid     = '0;
        i_abort     = '0;
        i_len       = '0;
        i_clr_drops = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        i_reset = 1'b1;
        cyc();
        cyc();
        i_reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            emitted[s] = 0;
            offered[s] = 0;
        end
    endtask

    initial begin
        int prev;
        int tap;
        int d1;

        tbl[0] = '{4'b1111, 4'b0000, {17'd40, 17'd30, 17'd20, 17'd10}, 1'b0, 31'h0};
        tbl[1] = '{4'b0000, 4'b0000, 68'd0, 1'b1, 31'h1000_0028};
        tbl[2] = '{4'b0000, 4'b0000, 68'd0, 1'b1, 31'h1400_0050};
        tbl[3] = '{4'b0000, 4'b0000, 68'd0, 1'b1, 31'h1800_0078};
        tbl[4] = '{4'b0100, 4'b0000, {17'd0, 17'd64, 34'd0}, 1'b1, 31'h1C00_00A0};
        tbl[5] = '{4'b0000, 4'b0000, 68'd0, 1'b1, 31'h1800_0100};
        tbl[6] = '{4'b0010, 4'b0010, 68'd0, 1'b0, 31'h0};
        tbl[7] = '{4'b0000, 4'b0000, 68'd0, 1'b1, 31'h1408_0000};
        tbl[8] = '{4'b0000, 4'b0000, 68'd0, 1'b0, 31'h0};

        do_reset();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_drops", 64'(o_drops), 64'd0);

        // Directed vectors: burst order, single event, abort/zero-length
        for (int i = 0; i < 9; i++) begin
            i_valid = tbl[i].v;
            i_abort = tbl[i].ab;
            i_len   = tbl[i].len;
            cyc();
            chk($sformatf("vec%0d_valid", i), 64'(o_valid), 64'(tbl[i].exp_v));
            chk($sformatf("vec%0d_data", i), 64'(o_data), 64'(tbl[i].exp_d));
        end
        chk("vec_drops", 64'(o_drops), 64'd0);

        // Fairness: taps 0 and 3 continuously offered
        do_reset();
        prev = -1;
        for (int c = 0; c < 40; c++) begin
            i_valid = 4'b1001;
            i_len   = {17'(c + 300), 34'd0, 17'(c + 100)};
            offered[0]++;
            offered[3]++;
            cyc();
            if (o_valid) begin
                tap = int'(o_data[27:26]);
                chk("fair_tap", 64'(tap == 0 || tap == 3), 64'd1);
                if (prev >= 0) chk("fair_alt", 64'(tap == prev), 64'd0);
                prev = tap;
            end else begin
                prev = -1;
            end
        end
        idle();
        for (int c = 0; c < 10; c++) cyc();
        chk("fair_drop0", 64'(o_drops[0 +: DROPW]), 64'(offered[0] - emitted[0]));
        chk("fair_drop3", 64'(o_drops[3*DROPW +: DROPW]), 64'(offered[3] - emitted[3]));

        // Overflow on tap 1 while the others stay saturated
        do_reset();
        for (int c = 0; c < 12; c++) begin
            i_valid = (c >= 2 && c < 8) ? 4'b1111 : 4'b1101;
            i_len   = {17'(c + 40), 17'(c + 30), 17'(c + 20), 17'(c + 10)};
            cyc();
        end
        idle();
        for (int c = 0; c < 24; c++) cyc();
        d1 = int'(o_drops[DROPW +: DROPW]);
        chk("ovf_total", 64'(emitted[1] + d1), 64'd6);
        chk("ovf_min_emit", 64'(emitted[1] >= 4), 64'd1);
        chk("ovf_some_drop", 64'(d1 > 0), 64'd1);

        // Saturate the drop counters, then clear during a drop
        do_reset();
        for (int c = 0; c < 4 * (DMAX + 6); c++) begin
            i_valid = 4'b1111;
            i_len   = 68'(c);
            cyc();
        end
        chk("sat_drop2", 64'(o_drops[2*DROPW +: DROPW]), 64'(DMAX));
        i_clr_drops = 1'b1;
        cyc();
        chk("clr_drops", 64'(o_drops), 64'd0);
        i_clr_drops = 1'b0;
        cyc();
        cyc();

        // Reset while every FIFO holds data
        do_reset();
        for (int c = 0; c < 6; c++) begin
            i_valid = 4'b1111;
            i_len   = {17'd4, 17'd3, 17'd2, 17'd1};
            cyc();
        end
        idle();
        i_reset = 1'b1;
        cyc();
        chk("midrst_valid", 64'(o_valid), 64'd0);
        chk("midrst_drops", 64'(o_drops), 64'd0);
        i_reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            chk("midrst_stale", 64'(o_valid), 64'd0);
        end

        // Random traffic
        do_reset();
        for (int c = 0; c < 500; c++) begin
            i_valid     = 4'($urandom);
            i_abort     = 4'($urandom);
            i_len       = {4'($urandom), 32'($urandom), 32'($urandom)};
            i_clr_drops = ($urandom_range(0, 31) == 0);
            cyc();
        end
        idle();
        for (int c = 0; c < 20; c++) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
